pll_reset_seq: RTL and testbench

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

---
 rtl/pll_reset_seq.sv | 135 +++++++++++++
 tb/tb_pll_reset_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_seq.sv
// PLL lock qualification and downstream reset sequencer (WAIT -> FILTER -> HOLD -> RUN).
// Define PLL_RESET_SEQ_LOSS_COUNT_EN to build the saturating loss counter; otherwise lost_count reads 0.
module pll_reset_seq #(
  parameter int unsigned LOCK_FILTER = 16,
  parameter int unsigned HOLD_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked,
  input  logic       clr_lost,
  output logic       rst_out,
  output logic       ready,
  output logic       lost_flag,
  output logic [7:0] lost_count
);

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    FILTER = 2'd1,
    HOLD   = 2'd2,
    RUN    = 2'd3
  } state_t;

  localparam logic [15:0] FILTER_LAST = 16'(LOCK_FILTER - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);

  logic        sync_q1;
  logic        lock_s;
  state_t      state;
  state_t      next_state;
  logic [15:0] cnt;
  logic [15:0] next_cnt;
  logic        loss_event;

  // locked comes from the PLL domain, so it is retimed before any decision uses it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      sync_q1 <= locked;
      lock_s  <= sync_q1;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    loss_event = 1'b0;
    case (state)
      WAIT: begin
        next_cnt = 16'd0;
        if (lock_s) next_state = FILTER;
      end
      FILTER: begin
        if (!lock_s) begin
          next_state = WAIT;
          next_cnt   = 16'd0;
        end else if (cnt == FILTER_LAST) begin
          next_state = HOLD;
          next_cnt   = 16'd0;
        end else begin
          next_cnt = cnt + 16'd1;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          next_state = WAIT;
          next_cnt   = 16'd0;
        end else if (cnt == HOLD_LAST) begin
          next_state = RUN;
          next_cnt   = 16'd0;
        end else begin
          next_cnt = cnt + 16'd1;
        end
      end
      RUN: begin
        next_cnt = 16'd0;
        if (!lock_s) begin
          next_state = WAIT;
          loss_event = 1'b1;
        end
      end
      default: begin
        next_state = WAIT;
        next_cnt   = 16'd0;
      end
    endcase
  end

  // Outputs are decoded from next_state so they flip on the same edge as RUN entry/exit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= WAIT;
      cnt     <= 16'd0;
      rst_out <= 1'b1;
      ready   <= 1'b0;
    end else begin
      state   <= next_state;
      cnt     <= next_cnt;
      rst_out <= (next_state != RUN);
      ready   <= (next_state == RUN);
    end
  end

  // A loss on the same edge as clr_lost takes priority over the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      lost_flag <= 1'b0;
    end else if (loss_event) begin
      lost_flag <= 1'b1;
    end else if (clr_lost) begin
      lost_flag <= 1'b0;
    end
  end

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      lost_count <= 8'd0;
    end else if (loss_event) begin
      if (clr_lost) begin
        lost_count <= 8'd1;
      end else if (lost_count != 8'hFF) begin
        lost_count <= lost_count + 8'd1;
      end
    end else if (clr_lost) begin
      lost_count <= 8'd0;
    end
  end
`else
  assign lost_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq: directed scenarios plus a random phase against a lock-streak model.
module tb_pll_reset_seq;

  localparam int LF       = 4;
  localparam int HC       = 8;
  localparam int RUN_LEN  = LF + HC + 1;
  // Edges counted inclusively from the first high sample of locked up to the edge where rst_out falls.
  localparam int LOCK_LAT = LF + HC + 3;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       locked   = 1'b0;
  logic       clr_lost = 1'b0;
  logic       rst_out;
  logic       ready;
  logic       lost_flag;
  logic [7:0] lost_count;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model: two-edge sampling delay, then a run of consecutive high samples seen by the sequencer.
  logic m_recent = 1'b0;
  logic m_older  = 1'b0;
  int   m_streak = 0;
  logic m_flag   = 1'b0;
  int   m_count  = 0;

  pll_reset_seq #(
    .LOCK_FILTER(LF),
    .HOLD_CYCLES(HC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .locked    (locked),
    .clr_lost  (clr_lost),
    .rst_out   (rst_out),
    .ready     (ready),
    .lost_flag (lost_flag),
    .lost_count(lost_count)
  );

  always #5 clk = ~clk;

  function automatic void modelEdge(input logic lk, input logic clr, input logic rst);
    logic seen;
    logic loss;
    if (rst) begin
      m_recent = 1'b0;
      m_older  = 1'b0;
      m_streak = 0;
      m_flag   = 1'b0;
      m_count  = 0;
    end else begin
      seen     = m_older;
      m_older  = m_recent;
      m_recent = lk;
      loss     = 1'b0;
      if (seen) begin
        if (m_streak < RUN_LEN) m_streak = m_streak + 1;
      end else begin
        loss     = (m_streak >= RUN_LEN);
        m_streak = 0;
      end
      if (loss) begin
        m_flag  = 1'b1;
        m_count = clr ? 1 : ((m_count < 255) ? m_count + 1 : 255);
      end else if (clr) begin
        m_flag  = 1'b0;
        m_count = 0;
      end
    end
  endfunction

  task automatic applyStimulus(input logic lk, input logic clr, input logic rst);
    @(negedge clk);
    locked   = lk;
    clr_lost = clr;
    reset    = rst;
    modelEdge(lk, clr, rst);
    @(posedge clk);
    #1;
  endtask

  task automatic checkEq(input string tag, input string what, input logic [31:0] got,
                         input logic [31:0] exp);
    n_asserts++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s %s: observed %0d expected %0d", tag, what, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkEq(tag, "rst_out", 32'(rst_out), (m_streak < RUN_LEN) ? 32'd1 : 32'd0);
    checkEq(tag, "ready", 32'(ready), (m_streak >= RUN_LEN) ? 32'd1 : 32'd0);
    checkEq(tag, "lost_flag", 32'(lost_flag), 32'(m_flag));
    checkEq(tag, "lost_count", 32'(lost_count), CNT_EN ? 32'(m_count) : 32'd0);
  endtask

  task automatic runLocked(input string tag, output int edges);
    edges = 0;
    do begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput(tag);
      edges++;
    end while (rst_out === 1'b1 && edges < 60);
  endtask

  task automatic lossAndRelock(input string tag);
    int edges;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput(tag);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput(tag);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput(tag);
    runLocked(tag, edges);
    checkEq(tag, "relock_edges", 32'(edges), 32'(LOCK_LAT - 2));
  endtask

  initial begin
    int edges;
    $display("[TB] start LOCK_FILTER=%0d HOLD_CYCLES=%0d count_en=%0d", LF, HC, CNT_EN);

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("reset");
    checkEq("reset", "rst_out_const", 32'(rst_out), 32'd1);
    checkEq("reset", "ready_const", 32'(ready), 32'd0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("scen1_idle");
    end
    runLocked("scen1", edges);
    checkEq("scen1", "lock_edges", 32'(edges), 32'(LOCK_LAT));
    checkEq("scen1", "ready_const", 32'(ready), 32'd1);

    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("scen2_reset");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("scen2_idle");
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("scen2_hold");
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("scen2_drop");
    runLocked("scen2", edges);
    checkEq("scen2", "lock_edges", 32'(edges), 32'(LOCK_LAT));
    checkEq("scen2", "lost_flag_const", 32'(lost_flag), 32'd0);
    checkEq("scen2", "lost_count_const", 32'(lost_count), 32'd0);

    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("scen3_j");
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkEq("scen3", "rst_out_j1", 32'(rst_out), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkEq("scen3", "rst_out_j2", 32'(rst_out), 32'd1);
    checkEq("scen3", "ready_j2", 32'(ready), 32'd0);
    checkEq("scen3", "lost_flag_j2", 32'(lost_flag), 32'd1);
    checkEq("scen3", "lost_count_j2", 32'(lost_count), CNT_EN ? 32'd1 : 32'd0);
    runLocked("scen3", edges);
    checkEq("scen3", "relock_edges", 32'(edges), 32'(LOCK_LAT - 2));

    for (int i = 0; i < 300; i++) lossAndRelock("scen4_loss");
    checkEq("scen4", "count_sat", 32'(lost_count), CNT_EN ? 32'd255 : 32'd0);
    checkEq("scen4", "flag_sat", 32'(lost_flag), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("scen4_clr");
    checkEq("scen4", "count_clr", 32'(lost_count), 32'd0);
    checkEq("scen4", "flag_clr", 32'(lost_flag), 32'd0);
    lossAndRelock("scen4_pre");
    lossAndRelock("scen4_pre");
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("scen4_coin");
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("scen4_coin");
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("scen4_coin");
    checkEq("scen4", "count_coin", 32'(lost_count), CNT_EN ? 32'd1 : 32'd0);
    checkEq("scen4", "flag_coin", 32'(lost_flag), 32'd1);
    runLocked("scen4_relock", edges);

    applyStimulus(1'b1, 1'b0, 1'b1);
    checkEq("scen5", "rst_out", 32'(rst_out), 32'd1);
    checkEq("scen5", "ready", 32'(ready), 32'd0);
    checkEq("scen5", "lost_count", 32'(lost_count), 32'd0);
    checkEq("scen5", "lost_flag", 32'(lost_flag), 32'd0);
    runLocked("scen5", edges);
    checkEq("scen5", "lock_edges", 32'(edges), 32'(LOCK_LAT));

    for (int i = 0; i < 3; i++) lossAndRelock("scen6_loss");
    checkEq("scen6", "lost_count", 32'(lost_count), CNT_EN ? 32'd3 : 32'd0);
    checkEq("scen6", "lost_flag", 32'(lost_flag), 32'd1);

    for (int i = 0; i < 1000; i++) begin
      applyStimulus(($urandom_range(0, 24) != 0), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 299) == 0));
      checkOutput("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
